// File: rtl/img_filter_pkg.sv
// Shared types and constants for the 3x3 streaming image filter.
// Kernel coefficient table, per-kernel shift, accumulator and FIFO sizing helpers.
// No logic; imported by the filter top and the line buffer.
package img_filter_pkg;

   typedef enum logic [1:0] {
      MODE_PASS  = 2'd0,
      MODE_GAUSS = 2'd1,
      MODE_SHARP = 2'd2,
      MODE_LAPL  = 2'd3
   } mode_e;

   localparam int COEF_W = 5;
   typedef logic signed [COEF_W-1:0] coef_t;

   // Window index k = row*3 + col, row 0 is the oldest line, col 2 the newest pixel.
   localparam coef_t COEF_TAB [4][9] = '{
      '{ 5'sd0,  5'sd0,  5'sd0,  5'sd0,  5'sd1,  5'sd0,  5'sd0,  5'sd0,  5'sd0},
      '{ 5'sd1,  5'sd2,  5'sd1,  5'sd2,  5'sd4,  5'sd2,  5'sd1,  5'sd2,  5'sd1},
      '{ 5'sd0, -5'sd1,  5'sd0, -5'sd1,  5'sd5, -5'sd1,  5'sd0, -5'sd1,  5'sd0},
      '{-5'sd1, -5'sd1, -5'sd1, -5'sd1,  5'sd8, -5'sd1, -5'sd1, -5'sd1, -5'sd1}
   };

   // Arithmetic right shift applied to the kernel sum, indexed by mode.
   localparam int unsigned SHIFT_TAB [4] = '{0, 4, 0, 0};

   // Signed accumulator wide enough for 16 * max pixel plus sign.
   function automatic int acc_w(input int pix_w);
      return pix_w + 5;
   endfunction

   function automatic int fifo_aw(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/img_line_buffer.sv
// One-line delay: circular buffer of DEPTH pixels, tap is the pixel written DEPTH writes ago.
// Latency: DEPTH accepted writes; tap is a combinational read of the current slot.
// No backpressure; advances only on wr_en.
module img_line_buffer
   import img_filter_pkg::*;
#(
   parameter int DEPTH = 512,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] tap
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    ptr;

   // The slot about to be overwritten holds the value from one line ago.
   assign tap = mem[ptr];

   // Circular write pointer, wraps at DEPTH-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (wr_en) begin
         ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
      end
   end

   // Storage needs no reset: rows above the frame start never form a valid window.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[ptr] <= din;
      end
   end

endmodule

// File: rtl/img_stream_filter3x3.sv
// Streaming 3x3 image filter, run-time kernel select; IMG_CLAMP_EN saturates results instead of wrapping.
// Latency: 3 cycles accept -> FIFO write (window reg, products reg, sum reg), FIFO adds one to output.
// Backpressure: o_data_ready drops when FIFO count plus in-flight results exceeds OUT_DEPTH-4.
module img_stream_filter3x3
   import img_filter_pkg::*;
#(
   parameter int PIX_W     = 8,
   parameter int IMG_W     = 512,
   parameter int IMG_H     = 512,
   parameter int OUT_DEPTH = 32
) (
   input  logic             axi_clk,
   input  logic             axi_reset,
   input  logic [1:0]       i_mode,
   input  logic             i_data_valid,
   input  logic [PIX_W-1:0] i_data,
   output logic             o_data_ready,
   output logic             o_data_valid,
   output logic [PIX_W-1:0] o_data,
   input  logic             i_data_ready,
   output logic             o_intr,
   output logic             o_overflow
);

   localparam int ACC_W   = acc_w(PIX_W);
   localparam int FIFO_AW = fifo_aw(OUT_DEPTH);
   localparam int COL_W   = $clog2(IMG_W);
   localparam int ROW_W   = $clog2(IMG_H);
   localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

   logic                accept;
   logic [COL_W-1:0]    col;
   logic [ROW_W-1:0]    row;
   mode_e               mode_q;
   logic [PIX_W-1:0]    tap1, tap0;
   logic [PIX_W-1:0]    win [9];
   logic                s0_vld, s0_last;
   logic signed [ACC_W-1:0] prod [9];
   mode_e               s1_mode;
   logic                s1_vld, s1_last;
   logic signed [ACC_W-1:0] sum_c, shf_c;
   logic [PIX_W-1:0]    res_c;
   logic [PIX_W-1:0]    s2_dat;
   logic                s2_vld, s2_last;
   logic [PIX_W-1:0]    fifo_mem [OUT_DEPTH];
   logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
   logic [FIFO_AW:0]    count;
   logic [FIFO_AW+1:0]  total;
   logic                full, fifo_wr, fifo_rd;

   assign accept  = i_data_valid && o_data_ready;
   assign full    = (count == (FIFO_AW+1)'(OUT_DEPTH));
   assign fifo_wr = s2_vld && !full;
   assign fifo_rd = o_data_valid && i_data_ready;
   assign total   = (FIFO_AW+2)'(count) + (FIFO_AW+2)'(s0_vld)
                  + (FIFO_AW+2)'(s1_vld) + (FIFO_AW+2)'(s2_vld);

   assign o_data_valid = (count != '0);
   assign o_data       = o_data_valid ? fifo_mem[rd_ptr] : '0;
   assign o_intr       = s2_vld && s2_last;

   // Raster position of the next pixel; mode is captured on each frame's first pixel.
   always_ff @(posedge axi_clk or posedge axi_reset) begin
      if (axi_reset) begin
         col    <= '0;
         row    <= '0;
         mode_q <= MODE_PASS;
      end else if (accept) begin
         if (col == '0 && row == '0) begin
            mode_q <= mode_e'(i_mode);
         end
         if (col == COL_W'(IMG_W - 1)) begin
            col <= '0;
            row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   img_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line1 (
      .clk   (axi_clk),
      .rst   (axi_reset),
      .wr_en (accept),
      .din   (i_data),
      .tap   (tap1)
   );

   img_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line0 (
      .clk   (axi_clk),
      .rst   (axi_reset),
      .wr_en (accept),
      .din   (tap1),
      .tap   (tap0)
   );

   // 3x3 window shifts left on every accept; valid once two full rows and columns precede it.
   always_ff @(posedge axi_clk or posedge axi_reset) begin
      if (axi_reset) begin
         for (int k = 0; k < 9; k++) win[k] <= '0;
         s0_vld  <= 1'b0;
         s0_last <= 1'b0;
      end else begin
         if (accept) begin
            for (int r = 0; r < 3; r++) begin
               win[r*3]   <= win[r*3+1];
               win[r*3+1] <= win[r*3+2];
            end
            win[2] <= tap0;
            win[5] <= tap1;
            win[8] <= i_data;
         end
         s0_vld  <= accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
         s0_last <= accept && (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));
      end
   end

   // Coefficient products; mode travels with the data so a new frame cannot disturb the old one.
   always_ff @(posedge axi_clk or posedge axi_reset) begin
      if (axi_reset) begin
         for (int k = 0; k < 9; k++) prod[k] <= '0;
         s1_mode <= MODE_PASS;
         s1_vld  <= 1'b0;
         s1_last <= 1'b0;
      end else begin
         for (int k = 0; k < 9; k++) begin
            prod[k] <= ACC_W'(COEF_TAB[mode_q][k]) * $signed({{(ACC_W-PIX_W){1'b0}}, win[k]});
         end
         s1_mode <= mode_q;
         s1_vld  <= s0_vld;
         s1_last <= s0_last;
      end
   end

   // Sum, shift, optional absolute value, then saturate or wrap to pixel width.
   always_comb begin
      sum_c = '0;
      for (int k = 0; k < 9; k++) sum_c = sum_c + prod[k];
      shf_c = sum_c >>> SHIFT_TAB[s1_mode];
      if (s1_mode == MODE_LAPL && shf_c[ACC_W-1]) begin
         shf_c = -shf_c;
      end
`ifdef IMG_CLAMP_EN
      if (shf_c[ACC_W-1]) begin
         res_c = '0;
      end else if (shf_c > PIX_MAX) begin
         res_c = '1;
      end else begin
         res_c = shf_c[PIX_W-1:0];
      end
`else
      res_c = shf_c[PIX_W-1:0];
`endif
   end

`ifndef IMG_CLAMP_EN
   // Upper bits are discarded when results wrap.
   logic unused_hi;
   assign unused_hi = ^shf_c[ACC_W-1:PIX_W];
`endif

   // Result register feeding the FIFO write port.
   always_ff @(posedge axi_clk or posedge axi_reset) begin
      if (axi_reset) begin
         s2_dat  <= '0;
         s2_vld  <= 1'b0;
         s2_last <= 1'b0;
      end else begin
         s2_dat  <= res_c;
         s2_vld  <= s1_vld;
         s2_last <= s1_last;
      end
   end

   // FIFO pointers, occupancy, sticky overflow and registered input-side ready.
   always_ff @(posedge axi_clk or posedge axi_reset) begin
      if (axi_reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         o_overflow   <= 1'b0;
         o_data_ready <= 1'b1;
      end else begin
         if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
         if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
         if (fifo_wr && !fifo_rd) begin
            count <= count + 1'b1;
         end else if (!fifo_wr && fifo_rd) begin
            count <= count - 1'b1;
         end
         if (s2_vld && full) o_overflow <= 1'b1;
         o_data_ready <= (total <= (FIFO_AW+2)'(OUT_DEPTH - 4));
      end
   end

   // FIFO storage; the head slot is never written while it is being presented.
   always_ff @(posedge axi_clk) begin
      if (fifo_wr) begin
         fifo_mem[wr_ptr] <= s2_dat;
      end
   end

endmodule
